// File: rtl/uart_frame_parser.sv
// uart_frame_parser: decodes 'P'/type/payload/CR/LF byte frames into measurement words and status flags
module uart_frame_parser #(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TMR_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        frame_valid,
  output logic        is_high,
  output logic        is_triple,
  output logic [31:0] data0,
  output logic [31:0] data1,
  output logic [31:0] data2,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [15:0] frame_cnt
);
  typedef enum logic [2:0] {IDLE, TYPE, DATA, CR, LF, DONE} state_t;
  state_t state, state_nx;
  logic [TMR_W-1:0] tmr;
  logic [95:0] sh;
  logic [3:0] idx;
  logic high_n, triple_n, timeout, in_frame;
  logic [1:0] err_nx;
  assign in_frame = state inside {TYPE, DATA, CR, LF};
  assign timeout = !rx_valid && in_frame && tmr == TMR_W'(TIMEOUT_CYCLES);
  always_comb begin
    state_nx = state == DONE ? IDLE : state;
    err_nx = 2'b00;
    if (timeout) begin
      state_nx = IDLE;
      err_nx = 2'b11;
    end else if (rx_valid) begin
      case (state)
        IDLE, DONE: state_nx = rx_data == 8'h50 ? TYPE : IDLE;
        TYPE: begin
          state_nx = rx_data inside {8'h31, 8'h32, 8'h33, 8'h34} ? DATA : rx_data == 8'h50 ? TYPE : IDLE;
          err_nx = state_nx == IDLE ? 2'b01 : 2'b00;
        end
        DATA: state_nx = idx == (triple_n ? 4'd11 : 4'd3) ? CR : DATA;
        CR: begin
          state_nx = rx_data == 8'h0D ? LF : IDLE;
          err_nx = state_nx == IDLE ? 2'b10 : 2'b00;
        end
        LF: begin
          state_nx = rx_data == 8'h0A ? DONE : IDLE;
          err_nx = state_nx == IDLE ? 2'b10 : 2'b00;
        end
        default: state_nx = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tmr <= '0;
      sh <= '0;
      idx <= '0;
      high_n <= 1'b0;
      triple_n <= 1'b0;
      frame_valid <= 1'b0;
      is_high <= 1'b0;
      is_triple <= 1'b0;
      data0 <= '0;
      data1 <= '0;
      data2 <= '0;
      frame_err <= 1'b0;
      err_code <= 2'b00;
      frame_cnt <= '0;
    end else begin
      state <= state_nx;
      tmr <= (rx_valid || !in_frame || timeout) ? '0 : tmr + 1'b1;
      frame_err <= |err_nx;
      if (|err_nx) err_code <= err_nx;
      frame_valid <= state == DONE;
      if (rx_valid && state == TYPE) begin
        high_n <= rx_data == 8'h31 || rx_data == 8'h33;
        triple_n <= rx_data == 8'h33 || rx_data == 8'h34;
        idx <= '0;
      end
      if (rx_valid && state == DATA) begin
        sh <= {sh[87:0], rx_data};
        idx <= idx + 1'b1;
      end
      if (state == DONE) begin
        data0 <= triple_n ? sh[95:64] : sh[31:0];
        data1 <= triple_n ? sh[63:32] : '0;
        data2 <= triple_n ? sh[31:0] : '0;
        is_high <= high_n;
        is_triple <= triple_n;
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser: scoreboard bench for uart_frame_parser with directed frames
module tb_uart_frame_parser;
  localparam int TO = 20;
  logic clk = 1'b0, rst = 1'b1, rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic frame_valid, is_high, is_triple, frame_err;
  logic [31:0] data0, data1, data2;
  logic [1:0] err_code;
  logic [15:0] frame_cnt;
  int passed = 0, total = 0;
  typedef struct {
    logic err;
    logic [1:0] code;
    logic hi, tr;
    logic [31:0] d0, d1, d2;
    logic [15:0] cnt;
  } exp_t;
  exp_t q[$];
  uart_frame_parser #(.TIMEOUT_CYCLES(TO), .TMR_W(16)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_valid(frame_valid), .is_high(is_high), .is_triple(is_triple),
    .data0(data0), .data1(data1), .data2(data2),
    .frame_err(frame_err), .err_code(err_code), .frame_cnt(frame_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic push_v(input logic hi, input logic tr, input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2, input logic [15:0] cnt);
    q.push_back('{1'b0, 2'b00, hi, tr, d0, d1, d2, cnt});
  endtask
  task automatic push_e(input logic [1:0] code, input logic [31:0] d0, input logic [15:0] cnt);
    q.push_back('{1'b1, code, 1'b0, 1'b0, d0, 32'h0, 32'h0, cnt});
  endtask
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask
  task automatic send_seq(input logic [7:0] b[$]);
    foreach (b[i]) send(b[i]);
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk_zero(input string tag);
    @(negedge clk);
    chk({tag, " frame_valid"}, {31'h0, frame_valid}, 32'h0);
    chk({tag, " frame_err"}, {31'h0, frame_err}, 32'h0);
    chk({tag, " data0"}, data0, 32'h0);
    chk({tag, " flags"}, {28'h0, is_high, is_triple, err_code}, 32'h0);
    chk({tag, " frame_cnt"}, {16'h0, frame_cnt}, 32'h0);
  endtask
  always @(negedge clk) begin
    if (!rst && (frame_valid || frame_err)) begin
      if (q.size() == 0) chk("unexpected event", {30'h0, frame_valid, frame_err}, 32'h0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("event kind", {30'h0, frame_valid, frame_err}, e.err ? 32'h1 : 32'h2);
        chk("data0", data0, e.d0);
        chk("frame_cnt", {16'h0, frame_cnt}, {16'h0, e.cnt});
        if (e.err) chk("err_code", {30'h0, err_code}, {30'h0, e.code});
        else begin
          chk("is_high", {31'h0, is_high}, {31'h0, e.hi});
          chk("is_triple", {31'h0, is_triple}, {31'h0, e.tr});
          chk("data1", data1, e.d1);
          chk("data2", data2, e.d2);
        end
      end
    end
  end
  initial begin
    idle(2);
    chk_zero("reset");
    rst = 1'b0;
    idle(1);
    push_v(1, 0, 32'h12345678, 0, 0, 1);
    send_seq('{8'h50, 8'h31, 8'h12, 8'h34, 8'h56, 8'h78, 8'h0D, 8'h0A});
    idle(3);
    push_e(2'b10, 32'h12345678, 1);
    send_seq('{8'h50, 8'h32, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h0D, 8'h0B});
    idle(3);
    push_v(0, 1, 32'd1000, 32'd2000, 32'd1000000, 2);
    send_seq('{8'h50, 8'h34, 8'h00, 8'h00, 8'h03, 8'hE8, 8'h00, 8'h00, 8'h07, 8'hD0,
               8'h00, 8'h0F, 8'h42, 8'h40, 8'h0D, 8'h0A});
    push_v(1, 0, 32'h500D0A50, 0, 0, 3);
    send_seq('{8'h41, 8'h50, 8'h50, 8'h31, 8'h50, 8'h0D, 8'h0A, 8'h50, 8'h0D, 8'h0A});
    idle(3);
    push_e(2'b01, 32'h500D0A50, 3);
    send_seq('{8'h50, 8'h39});
    idle(3);
    push_e(2'b11, 32'h500D0A50, 3);
    send_seq('{8'h50, 8'h33, 8'h01});
    idle(TO + 4);
    push_v(1, 0, 32'h12345678, 0, 0, 4);
    send_seq('{8'h50, 8'h31, 8'h12});
    idle(TO);
    send_seq('{8'h34, 8'h56, 8'h78, 8'h0D, 8'h0A});
    idle(3);
    send_seq('{8'h50, 8'h31, 8'h12, 8'h34, 8'h56});
    rst = 1'b1;
    idle(1);
    chk_zero("mid-frame reset");
    rst = 1'b0;
    idle(1);
    push_v(1, 0, 32'h12345678, 0, 0, 1);
    send_seq('{8'h50, 8'h31, 8'h12, 8'h34, 8'h56, 8'h78, 8'h0D, 8'h0A});
    idle(5);
    chk("pending events", q.size(), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
